// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction memory boot loader.
// Frame flags are packed as {eof, sof} so they can be masked out of a single vector.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

    localparam logic [1:0] FLAG_SOF = 2'b01;
    localparam logic [1:0] FLAG_EOF = 2'b10;

    function automatic int lane_width(input int data_w);
        return (data_w / 8 > 1) ? $clog2(data_w / 8) : 1;
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/instr_byte_packer.sv
// Packs accepted bytes little-endian into a word and flags when a word
// (complete, or partial at end of frame) must be written to memory.
module instr_byte_packer
    import instr_mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              byte_en,
    input  logic              restart,
    input  logic              last,
    input  logic [7:0]        byte_in,
    output logic              word_we,
    output logic              word_partial,
    output logic [DATA_W-1:0] word_data
);

    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = lane_width(DATA_W);

    logic [LANE_W-1:0] lane;
    logic [LANE_W-1:0] lane_cur;
    logic [DATA_W-1:0] pack;
    logic [DATA_W-1:0] pack_cur;
    logic [DATA_W-1:0] merged;
    logic              full;

    // A restart discards whatever was half-packed, so the new byte lands in lane 0.
    always_comb begin
        lane_cur = restart ? '0 : lane;
        pack_cur = restart ? '0 : pack;
        merged   = pack_cur | (DATA_W'(byte_in) << (8 * lane_cur));
        full     = (lane_cur == LANE_W'(LANES - 1));
    end

    assign word_we      = byte_en && (full || last);
    assign word_partial = byte_en && last && !full;
    assign word_data    = merged;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane <= '0;
            pack <= '0;
        end else if (byte_en) begin
            if (full || last) begin
                lane <= '0;
                pack <= '0;
            end else begin
                lane <= lane_cur + LANE_W'(1);
                pack <= merged;
            end
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with a byte-serial boot loader; the CPU reads it
// combinationally and is stalled while a frame is being loaded.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 64,
    localparam int LANES  = DATA_W / 8,
    localparam int ADDR_W = addr_width(DEPTH),
    localparam int LANE_W = lane_width(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_data,
    input  logic              ld_sof,
    input  logic              ld_eof,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [31:0]       rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              cpu_stall,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    load_state_t       state;
    logic [ADDR_W:0]   addr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        frame_flags;
    logic              accept;
    logic              sof_acc;
    logic              eof_acc;
    logic              pack_en;
    logic              word_we;
    logic              word_partial;
    logic [DATA_W-1:0] word_data;

    logic [ADDR_W:0]   addr_eff;
    logic [ADDR_W:0]   words_eff;
    logic              in_range;
    logic              mem_we;
    logic [ADDR_W:0]   addr_next;
    logic [ADDR_W:0]   words_next;
    logic              err_next;

    logic [ADDR_W-1:0] rd_idx;
    logic              rd_addr_unused;

    assign frame_flags = {ld_eof, ld_sof};
    assign accept      = ld_valid && ld_ready;
    assign sof_acc     = accept && |(frame_flags & FLAG_SOF);
    assign eof_acc     = accept && |(frame_flags & FLAG_EOF);
    assign pack_en     = sof_acc || (accept && state == LOAD);

    instr_byte_packer #(
        .DATA_W(DATA_W)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .byte_en     (pack_en),
        .restart     (sof_acc),
        .last        (eof_acc),
        .byte_in     (ld_data),
        .word_we     (word_we),
        .word_partial(word_partial),
        .word_data   (word_data)
    );

    // A sof byte retargets the frame in the same cycle, so its own word uses ld_base.
    always_comb begin
        addr_eff   = sof_acc ? {1'b0, ld_base} : addr;
        words_eff  = sof_acc ? '0 : words_loaded;
        in_range   = addr_eff < (ADDR_W + 1)'(DEPTH);
        mem_we     = word_we && in_range;
        addr_next  = mem_we ? addr_eff + (ADDR_W + 1)'(1) : addr_eff;
        words_next = mem_we ? words_eff + (ADDR_W + 1)'(1) : words_eff;
        err_next   = ((state == IDLE && sof_acc) ? 1'b0 : load_err)
                   | (state == LOAD && sof_acc)
                   | word_partial
                   | (word_we && !in_range);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ld_ready     <= 1'b1;
            cpu_stall    <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            addr         <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sof_acc) begin
                        state     <= eof_acc ? DONE : LOAD;
                        cpu_stall <= 1'b1;
                        ld_ready  <= !eof_acc;
                        load_done <= eof_acc;
                    end
                end
                LOAD: begin
                    if (eof_acc) begin
                        state     <= DONE;
                        ld_ready  <= 1'b0;
                        load_done <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    ld_ready  <= 1'b1;
                    cpu_stall <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    ld_ready  <= 1'b1;
                    cpu_stall <= 1'b0;
                end
            endcase
            if (pack_en) begin
                addr         <= addr_next;
                words_loaded <= words_next;
                load_err     <= err_next;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[addr_eff[ADDR_W-1:0]] <= word_data;
        end
    end

    // Byte-offset and high address bits are dropped, so fetches wrap around the array.
    assign rd_idx         = rd_addr[LANE_W+ADDR_W-1:LANE_W];
    assign rd_data        = mem[rd_idx];
    assign rd_addr_unused = ^{rd_addr[31:LANE_W+ADDR_W], rd_addr[LANE_W-1:0]};

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a per-cycle vector table plus
// hand-written sequences for back-to-back streaming and mid-frame reset.
module tb_instr_mem_loader;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              ld_valid;
    logic              ld_ready;
    logic [7:0]        ld_data;
    logic              ld_sof;
    logic              ld_eof;
    logic [ADDR_W-1:0] ld_base;
    logic [31:0]       rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              cpu_stall;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        sof;
        logic        eof;
        logic [5:0]  base;
        logic        chk_rd;
        logic [31:0] ra;
        logic [31:0] exp_rd;
        logic        e_ready;
        logic        e_stall;
        logic        e_done;
        logic        e_err;
        logic [6:0]  e_words;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    instr_mem_loader #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_sof      (ld_sof),
        .ld_eof      (ld_eof),
        .ld_base     (ld_base),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .cpu_stall   (cpu_stall),
        .load_done   (load_done),
        .load_err    (load_err),
        .words_loaded(words_loaded)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_byte(input logic [7:0] d, input logic sof, input logic eof,
                            input logic [5:0] base, input logic er, input logic es,
                            input logic ed, input logic ee, input logic [6:0] ew);
        vec_t t;
        t.v = 1'b1; t.d = d; t.sof = sof; t.eof = eof; t.base = base;
        t.chk_rd = 1'b0; t.ra = 32'h0; t.exp_rd = 32'h0;
        t.e_ready = er; t.e_stall = es; t.e_done = ed; t.e_err = ee; t.e_words = ew;
        vecs.push_back(t);
    endtask

    task automatic add_read(input logic [31:0] ra, input logic [31:0] exp_rd,
                            input logic ee, input logic [6:0] ew);
        vec_t t;
        t.v = 1'b0; t.d = 8'h00; t.sof = 1'b0; t.eof = 1'b0; t.base = 6'd0;
        t.chk_rd = 1'b1; t.ra = ra; t.exp_rd = exp_rd;
        t.e_ready = 1'b1; t.e_stall = 1'b0; t.e_done = 1'b0; t.e_err = ee; t.e_words = ew;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input vec_t t, input int idx);
        @(negedge clk);
        ld_valid = t.v;
        ld_data  = t.d;
        ld_sof   = t.sof;
        ld_eof   = t.eof;
        ld_base  = t.base;
        rd_addr  = t.ra;
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d ld_ready", idx), 32'(ld_ready), 32'(t.e_ready));
        checkOutput($sformatf("v%0d cpu_stall", idx), 32'(cpu_stall), 32'(t.e_stall));
        checkOutput($sformatf("v%0d load_done", idx), 32'(load_done), 32'(t.e_done));
        checkOutput($sformatf("v%0d load_err", idx), 32'(load_err), 32'(t.e_err));
        checkOutput($sformatf("v%0d words_loaded", idx), 32'(words_loaded), 32'(t.e_words));
        if (t.chk_rd) begin
            checkOutput($sformatf("v%0d rd_data@0x%0h", idx, t.ra), rd_data, t.exp_rd);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        int done_cnt;
        int stall_cnt;
        int waited;
        bit acc;

        reset = 1'b1; ld_valid = 1'b0; ld_data = 8'h00; ld_sof = 1'b0; ld_eof = 1'b0;
        ld_base = '0; rd_addr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset ld_ready", 32'(ld_ready), 32'd1);
        checkOutput("reset cpu_stall", 32'(cpu_stall), 32'd0);
        checkOutput("reset load_done", 32'(load_done), 32'd0);
        checkOutput("reset load_err", 32'(load_err), 32'd0);
        checkOutput("reset words_loaded", 32'(words_loaded), 32'd0);
        checkOutput("reset rd_data", rd_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Frame 1: 01..08 at base 0, two full words
        add_byte(8'h01, 1, 0, 6'd0, 1, 1, 0, 0, 7'd0);
        add_byte(8'h02, 0, 0, 6'd7, 1, 1, 0, 0, 7'd0);
        add_byte(8'h03, 0, 0, 6'd7, 1, 1, 0, 0, 7'd0);
        add_byte(8'h04, 0, 0, 6'd7, 1, 1, 0, 0, 7'd1);
        add_byte(8'h05, 0, 0, 6'd7, 1, 1, 0, 0, 7'd1);
        add_byte(8'h06, 0, 0, 6'd7, 1, 1, 0, 0, 7'd1);
        add_byte(8'h07, 0, 0, 6'd7, 1, 1, 0, 0, 7'd1);
        add_byte(8'h08, 0, 1, 6'd7, 0, 1, 1, 0, 7'd2);
        add_read(32'h0,   32'h04030201, 0, 7'd2);
        add_read(32'h4,   32'h08070605, 0, 7'd2);
        add_read(32'h104, 32'h08070605, 0, 7'd2);
        // Non-sof byte in IDLE is dropped silently
        add_byte(8'h77, 0, 1, 6'd2, 1, 0, 0, 0, 7'd2);
        add_read(32'h8,   32'h0, 0, 7'd2);
        // Frame 2: AA..AF at base 3, trailing partial word
        add_byte(8'hAA, 1, 0, 6'd3, 1, 1, 0, 0, 7'd0);
        add_byte(8'hAB, 0, 0, 6'd7, 1, 1, 0, 0, 7'd0);
        add_byte(8'hAC, 0, 0, 6'd7, 1, 1, 0, 0, 7'd0);
        add_byte(8'hAD, 0, 0, 6'd7, 1, 1, 0, 0, 7'd1);
        add_byte(8'hAE, 0, 0, 6'd7, 1, 1, 0, 0, 7'd1);
        add_byte(8'hAF, 0, 1, 6'd7, 0, 1, 1, 1, 7'd2);
        add_read(32'd12, 32'hADACABAA, 1, 7'd2);
        add_read(32'd16, 32'h0000AFAE, 1, 7'd2);
        add_read(32'd20, 32'h0, 1, 7'd2);
        // Frame 3: 12 bytes at base 62, third word overflows
        for (int k = 0; k < 12; k++) begin
            add_byte(8'h20 + 8'(k), (k == 0), (k == 11), (k == 0) ? 6'd62 : 6'd7,
                     (k != 11), 1, (k == 11), (k == 11), (k < 3) ? 7'd0 : (k < 7) ? 7'd1 : 7'd2);
        end
        add_read(32'd248, 32'h23222120, 1, 7'd2);
        add_read(32'd252, 32'h27262524, 1, 7'd2);
        add_read(32'd0,   32'h04030201, 1, 7'd2);
        // Frame 4: restart after 2 bytes at base 8, real frame at base 5
        add_byte(8'h55, 1, 0, 6'd8, 1, 1, 0, 0, 7'd0);
        add_byte(8'h66, 0, 0, 6'd7, 1, 1, 0, 0, 7'd0);
        add_byte(8'h11, 1, 0, 6'd5, 1, 1, 0, 1, 7'd0);
        add_byte(8'h12, 0, 0, 6'd7, 1, 1, 0, 1, 7'd0);
        add_byte(8'h13, 0, 0, 6'd7, 1, 1, 0, 1, 7'd0);
        add_byte(8'h14, 0, 1, 6'd7, 0, 1, 1, 1, 7'd1);
        add_read(32'd20, 32'h14131211, 1, 7'd1);
        add_read(32'd32, 32'h0, 1, 7'd1);
        // One-byte frame: sof and eof together
        add_byte(8'h5A, 1, 1, 6'd10, 0, 1, 1, 1, 7'd1);
        add_read(32'd40, 32'h0000005A, 1, 7'd1);

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Back-to-back frames with ld_valid held high across the DONE bubble
        done_cnt = 0;
        stall_cnt = 0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            ld_valid = 1'b1;
            ld_data  = (k < 4) ? 8'h81 + 8'(k) : 8'h91 + 8'(k - 4);
            ld_sof   = (k == 0 || k == 4);
            ld_eof   = (k == 3 || k == 7);
            ld_base  = (k < 4) ? 6'd20 : 6'd21;
            acc = 1'b0;
            waited = 0;
            while (!acc && waited < 20) begin
                #1;
                acc = ld_valid && ld_ready;
                if (!acc) stall_cnt++;
                @(posedge clk);
                #1;
                if (load_done) done_cnt++;
                @(negedge clk);
                waited++;
            end
            if (!acc) checkOutput($sformatf("stream byte %0d accepted", k), 32'd0, 32'd1);
        end
        ld_valid = 1'b0;
        ld_sof = 1'b0;
        ld_eof = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("stream load_done pulses", 32'(done_cnt), 32'd2);
        checkOutput("stream stall cycles", 32'(stall_cnt), 32'd1);
        checkOutput("stream load_err", 32'(load_err), 32'd0);
        checkOutput("stream words_loaded", 32'(words_loaded), 32'd1);
        checkOutput("stream cpu_stall", 32'(cpu_stall), 32'd0);
        rd_addr = 32'd80;
        #1;
        checkOutput("stream mem[20]", rd_data, 32'h84838281);
        rd_addr = 32'd84;
        #1;
        checkOutput("stream mem[21]", rd_data, 32'h94939291);

        // Reset asserted between clock edges while a frame is in progress
        @(negedge clk);
        ld_valid = 1'b1; ld_data = 8'hC1; ld_sof = 1'b1; ld_base = 6'd30;
        @(negedge clk);
        ld_data = 8'hC2; ld_sof = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midreset pre cpu_stall", 32'(cpu_stall), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midreset ld_ready", 32'(ld_ready), 32'd1);
        checkOutput("midreset cpu_stall", 32'(cpu_stall), 32'd0);
        checkOutput("midreset load_done", 32'(load_done), 32'd0);
        checkOutput("midreset load_err", 32'(load_err), 32'd0);
        checkOutput("midreset words_loaded", 32'(words_loaded), 32'd0);
        rd_addr = 32'd80;
        #1;
        checkOutput("midreset mem[20]", rd_data, 32'h0);
        rd_addr = 32'd0;
        #1;
        checkOutput("midreset mem[0]", rd_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        ld_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("postreset cpu_stall", 32'(cpu_stall), 32'd0);
        checkOutput("postreset ld_ready", 32'(ld_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Parametrised instruction memory with an integrated byte-serial boot loader. A host streams program bytes over a valid/ready byte channel framed by start/end-of-frame flags. The block packs them little-endian into words at an auto-incrementing address and reports completion and errors. The CPU fetch stage reads it combinationally and is stalled while a load is in progress.

## Interface
- DATA_W, 32, instruction word width; multiple of 8, ≥ 16
- DEPTH, 64, number of words
- LANES, DATA_W/8, bytes per word (derived, not overridden)
- ADDR_W, $clog2(DEPTH), word-index width (derived)
- LANE_W, $clog2(LANES), byte-lane index width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- ld_valid  in  1  byte presented
- ld_ready  out  1  block can accept a byte
- ld_data  in  8  byte payload
- ld_sof  in  1  first byte of frame (qualified by ld_valid)
- ld_eof  in  1  last byte of frame (qualified by ld_valid)
- ld_base  in  ADDR_W  start word index, sampled with the sof byte
- rd_addr  in  32  CPU byte address
- rd_data  out  DATA_W  instruction word at rd_addr
- cpu_stall  out  1  high while loading
- load_done  out  1  one-cycle pulse at frame end
- load_err  out  1  sticky error flag
- words_loaded  out  ADDR_W+1  words written in current or last frame

## Operation
- Byte accepted when ld_valid && ld_ready.
- FSM states are IDLE, LOAD and DONE.
- **IDLE** (ld_ready=1):
  - Non-sof bytes are dropped; no error is raised.
  - An accepted sof byte sets addr=ld_base, lane=0, words_loaded=0 and load_err=0.
  - The sof byte itself is stored in lane 0; lane becomes 1.
  - Next state is LOAD, or DONE if ld_eof is also set.
- **LOAD** (ld_ready=1, cpu_stall=1):
  - Each accepted byte goes into lane `lane` of the pack register; lane increments.
  - When lane==LANES-1, the full word (pack | byte<<8*(LANES-1)) is written to mem[addr]. Then addr+1, lane=0, words_loaded+1.
- **eof byte accepted:**
  - The byte is stored first.
  - If the word is partial (lane≠0 after storing), it is written zero-padded in the upper lanes, and load_err is set.
  - Next state is DONE.
- **sof accepted while in LOAD:**
  - Any partial word is discarded, load_err is set, and the frame restarts at the new ld_base.
  - load_err is not cleared on this restart.
- **Overflow:**
  - A word write with addr ≥ DEPTH is suppressed and sets load_err.
  - addr saturates at DEPTH; no wrap.
- **DONE** (ld_ready=0, cpu_stall=1): pulses load_done for one cycle, then goes to IDLE.
- **Read:** rd_data = mem[rd_addr[LANE_W+ADDR_W-1:LANE_W]]. Upper address bits are ignored, so reads wrap. The read is combinational and returns current contents during a load.
- Byte arithmetic:
  - ld_data is unsigned.
  - words_loaded counts written words only; it does not count suppressed words.

## Timing
- Reset values:
  - ld_ready=1, cpu_stall=0, load_done=0, load_err=0, words_loaded=0.
  - FSM in IDLE; all memory words 0; rd_data is therefore 0.
- Write latency:
  - The word is written at the clock edge that accepts its last byte.
  - rd_data reflects it in the cycle after that edge.
- Throughput: one byte per cycle sustained; ld_ready deasserts only in DONE (1 cycle per frame).
- load_done is asserted in the cycle after the eof-accepting edge.
- cpu_stall rises in the cycle after sof acceptance and falls in the cycle after DONE.
- Simultaneous sof+eof on one byte gives a 1-byte frame: the partial word is written and load_err is set.
- Reset mid-frame: asynchronous return to IDLE. Memory clears and any partial word is lost.
- ld_base, ld_sof and ld_eof are ignored unless the byte is accepted.

## Structure
- Package instr_mem_pkg holds:
  - the state enum (IDLE, LOAD, DONE);
  - the sof/eof frame-flag constants;
  - the lane and address width helper functions.
- Sub-module instr_byte_packer: lane counter, pack register, and word-complete/partial-flush outputs.
- The top level owns the FSM, address/overflow logic, memory array and read mux.

## Test plan
- Reset, then 8 bytes 01..08 with sof on the first and eof on the last, ld_base=0 → mem[0]=0x04030201, mem[1]=0x08070605. load_done pulses once, words_loaded=2, load_err=0.
- After loading, rd_addr=0x104 with DEPTH=64 (wraps) → rd_data=mem[1]=0x08070605.
- Frame of 6 bytes AA..AF at ld_base=3 → mem[3]=0xADACABAA, mem[4]=0x0000AFAE, load_err=1, words_loaded=2.
- ld_base=62 with a 12-byte frame → mem[62] and mem[63] written, third word suppressed, load_err=1, words_loaded=2.
- Mid-frame sof after 2 bytes, then 4 bytes 11..14 with eof at ld_base=5 → mem[5]=0x14131211, load_err=1, no write at the old base.
- Reset asserted during LOAD → all outputs at reset values; mem reads 0; ld_valid held high with ld_ready randomly stalled in DONE loses no bytes.
